// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decoder/fetch encodings and fetch FSM state type
package cpu_pkg;

    localparam logic [15:0] NOOP_INSTR = 16'hBF00;

    localparam logic [1:0] BR_LINK   = 2'b00;
    localparam logic [1:0] BR_COND   = 2'b01;
    localparam logic [1:0] BR_UNCOND = 2'b10;
    localparam logic [1:0] BR_NONE   = 2'b11;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - redirect target from PC, branch immediate or BX register
module branch_target (
    input  logic [15:0] pc,
    input  logic [10:0] imm,
    input  logic [1:0]  br_sel,
    input  logic        br_ex,
    input  logic [15:0] br_reg,
    output logic [15:0] target
);
    import cpu_pkg::*;

    logic [15:0] offset;

    always_comb begin
        offset = 16'h0000;
        case (br_sel)
            BR_COND:   offset = {{7{imm[7]}}, imm[7:0], 1'b0};
            BR_UNCOND: offset = {{4{imm[10]}}, imm[10:0], 1'b0};
            BR_LINK:   offset = {{9{imm[5]}}, imm[5:0], 1'b0};
            default:   offset = 16'h0000;
        endcase
        // BX targets are forced halfword aligned.
        if (br_ex) target = br_reg & 16'hFFFE;
        else       target = pc + 16'd4 + offset;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC holder and variable-latency instruction fetch feeding the decoder
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOOP_INSTR = 16'hBF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Branch,
    input  logic [1:0]  brSel,
    input  logic        brEx,
    input  logic [15:0] br_reg,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] PC,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] link_addr
);
    import cpu_pkg::*;

    fetch_state_t state_q, state_d;
    logic [15:0]  fetch_pc_q, fetch_pc_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic [15:0]  buf_q, buf_d;
    logic         outstanding_q, outstanding_d;
    logic [15:0]  target;
    logic         taken;
    logic         resp;

    branch_target u_branch_target (
        .pc     (pc_q),
        .imm    (instr_q[10:0]),
        .br_sel (brSel),
        .br_ex  (brEx),
        .br_reg (br_reg),
        .target (target)
    );

    assign taken       = instr_valid_q & Branch & ~stall & (brEx | (brSel != BR_NONE));
    assign resp        = imem_valid & outstanding_q;
    // A redirect in FETCH suppresses the wrong-path request outright.
    assign imem_req    = (state_q == FETCH) & ~taken & ~reset;
    assign imem_addr   = fetch_pc_q;
    assign PC          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign link_addr   = pc_q + 16'd2;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        buf_d         = buf_q;
        outstanding_d = outstanding_q;

        if (imem_valid) outstanding_d = 1'b0;
        if (imem_req)   outstanding_d = 1'b1;

        if (!stall) begin
            instr_d       = NOOP_INSTR;
            instr_valid_d = 1'b0;
        end

        if (taken) begin
            fetch_pc_d = target;
            buf_d      = NOOP_INSTR;
            state_d    = ((state_q == WAIT || state_q == DROP) && !resp) ? DROP : FETCH;
        end else begin
            case (state_q)
                FETCH: state_d = WAIT;
                WAIT: begin
                    if (resp) begin
                        if (!instr_valid_q || !stall) begin
                            pc_d          = fetch_pc_q;
                            instr_d       = imem_rdata;
                            instr_valid_d = 1'b1;
                            fetch_pc_d    = fetch_pc_q + 16'd2;
                            state_d       = FETCH;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_d          = fetch_pc_q;
                        instr_d       = buf_q;
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = fetch_pc_q + 16'd2;
                        state_d       = FETCH;
                    end
                end
                DROP: if (resp) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= NOOP_INSTR;
            instr_valid_q <= 1'b0;
            buf_q         <= NOOP_INSTR;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            buf_q         <= buf_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the cpuControl decoder.
- Holds the program counter and issues 16-bit instruction reads to instruction memory over a variable-latency req/valid interface.
- Registers the returned instruction and its address into the PC/instr pair consumed by the decoder.
- Resolves redirects from the decoder's Branch/brSel/brEx outputs, flushing any wrong-path fetch.

Parameters:
RESET_PC, 16'h0000, first fetch address after reset
NOOP_INSTR, 16'hBF00, bubble instruction presented to the decoder when instr_valid=0

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  downstream hold; freezes the output register and blocks redirect
Branch  in  1  decoder: current instr is a branch
brSel  in  2  decoder: 11 none, 01 conditional taken, 10 B, 00 BL
brEx  in  1  decoder: BX, target from register
br_reg  in  16  register value for BX target
imem_req  out  1  single-cycle read request
imem_addr  out  16  read address, valid with imem_req
imem_valid  in  1  read data valid, at least 1 cycle after req
imem_rdata  in  16  instruction word
PC  out  16  address of instr
instr  out  16  instruction to decoder
instr_valid  out  1  instr is real, not a bubble
link_addr  out  16  PC+2, link value for BL

Behaviour:
- Reset values: fetch_pc=RESET_PC, PC=RESET_PC, instr=NOOP_INSTR, instr_valid=0, imem_req=0, buffer empty, state=FETCH.
- First request is issued in the first cycle after reset deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=fetch_pc. Next state is WAIT. A taken redirect in the same cycle wins: next state stays FETCH at the target and no WAIT occurs.
  - WAIT: waits for imem_valid.
    - Output register free (instr_valid=0, or the output is being consumed because !stall): load PC<=fetch_pc, instr<=imem_rdata, instr_valid<=1, fetch_pc<=fetch_pc+2, next state FETCH.
    - stall=1 with output occupied: capture into a 1-entry buffer and go to HOLD.
  - HOLD: no requests issued. When stall drops, the buffer moves to the output register, fetch_pc+=2, next state FETCH.
  - DROP: a redirect occurred while a read was outstanding. Discard the next imem_valid, then go to FETCH at the already-updated fetch_pc.
- Taken redirect, taken = instr_valid & Branch & !stall & (brEx | brSel!=2'b11):
  - target when brEx=1: br_reg & 16'hFFFE.
  - target when brSel=01: PC+4+(sext(instr[7:0])<<1).
  - target when brSel=10: PC+4+(sext(instr[10:0])<<1).
  - target when brSel=00: PC+4+(sext(instr[5:0])<<1).
  - All target arithmetic is 16-bit with wrap-around modulo 2^16.
  - Effect on the next edge: fetch_pc<=target, instr<=NOOP_INSTR, instr_valid<=0, buffer cleared.
  - Next state: DROP if in WAIT with no imem_valid this cycle; else FETCH. A response arriving in the redirect cycle is dropped.
- Not-taken branches (brSel=11, brEx=0) are ordinary instructions.
- stall=1: PC/instr/instr_valid hold; redirects are ignored until stall=0.
- When the output is consumed and no new instruction is loaded, instr_valid<=0 and instr<=NOOP_INSTR.
- link_addr = PC+2 (combinational, wraps).
- Reset in any state, including WAIT or DROP, returns to reset values. The next imem_valid after reset is discarded only if a req was outstanding, which is tracked by an outstanding flag that reset clears. The memory must not return data for a request aborted by reset.
- Throughput: with 1-cycle memory, one instruction per 2 cycles.
- At most one read is outstanding at any time.

Decomposition:
- Shared package cpu_pkg holds:
  - NOOP_INSTR.
  - brSel encodings: BR_LINK=2'b00, BR_COND=2'b01, BR_UNCOND=2'b10, BR_NONE=2'b11.
  - fetch_state_t enum {FETCH, WAIT, HOLD, DROP}.
- One combinational sub-module, branch_target, computes target from PC, instr, brSel, brEx and br_reg.

Test Plan:
- Reset, 1-cycle memory returning {16'h2001, 16'h2102} at 0 and 2 -> imem_addr 0 then 2. instr=16'h2001 with PC=0 and instr_valid=1, then 16'h2102 with PC=2; instr_valid=0 on alternate cycles.
- stall=1 while WAIT returns 16'h1C48 -> HOLD, output unchanged, no imem_req. On stall=0, instr=16'h1C48 and the next req is at +2.
- PC=16'h0010, instr=16'hD0FC, Branch=1, brSel=01 -> next imem_addr 16'h000C (0x10+4-8); one NOOP bubble.
- brEx=1, br_reg=16'h0123 with a 3-cycle memory read outstanding -> DROP; stale data discarded; next imem_addr 16'h0122.
- PC=16'hFFFE, B with imm11=0 -> target 16'h0002 (wrap); link_addr=16'h0000 at PC=16'hFFFE.
- reset asserted mid-WAIT -> next cycle PC=RESET_PC, instr=16'hBF00, instr_valid=0; fetch restarts at RESET_PC.
